// File: rtl/hcsr04_pkg.sv
// hcsr04_pkg: state encoding and default timing shared by the HC-SR04 ranger, its top level and bench.
package hcsr04_pkg;
  typedef enum logic [2:0] {IDLE, TRIG, WAIT_RISE, MEASURE, HOLD} state_e;
  localparam int DEF_CLK_HZ        = 50_000_000;
  localparam int DEF_TRIG_CYCLES   = 500;
  localparam int DEF_CYCLES_PER_CM = 2900;
  localparam int DEF_ECHO_TIMEOUT  = 1_900_000;
  localparam int DEF_PERIOD_CYCLES = 3_000_000;
  localparam int DEF_MAX_CM        = 400;
endpackage

// File: rtl/hcsr04_ranger_sync2.sv
// sync2: two-flop synchronizer for a single asynchronous input bit.
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);
  logic [1:0] s_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) s_q <= 2'b00;
    else     s_q <= {s_q[0], d_i};
  end
  assign q_o = s_q[1];
endmodule

// File: rtl/hcsr04_ranger.sv
// hcsr04_ranger: periodic HC-SR04 trigger generator and echo-width to centimetre converter.
module hcsr04_ranger
  import hcsr04_pkg::*;
#(
  parameter int CLK_HZ        = DEF_CLK_HZ,
  parameter int TRIG_CYCLES   = DEF_TRIG_CYCLES,
  parameter int CYCLES_PER_CM = DEF_CYCLES_PER_CM,
  parameter int ECHO_TIMEOUT  = DEF_ECHO_TIMEOUT,
  parameter int PERIOD_CYCLES = DEF_PERIOD_CYCLES,
  parameter int MAX_CM        = DEF_MAX_CM
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        echo,
  output logic        trigger,
  output logic [15:0] cm,
  output logic        valid,
  output logic        timeout
);
  localparam int CW = $clog2(ECHO_TIMEOUT + TRIG_CYCLES);
  localparam int PW = $clog2(PERIOD_CYCLES);
  localparam int SW = $clog2(CYCLES_PER_CM + 1);
  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [PW-1:0] per_q;
  logic [SW-1:0] sub_q;
  logic [15:0]   acc_q, cm_q;
  logic          trig_q, valid_q, to_q, echo_prev_q;
  logic          echo_s, rise, fall, wrap;
  sync2 u_sync (.clk(clk), .rst(reset), .d_i(echo), .q_o(echo_s));
  assign rise = echo_s & ~echo_prev_q;
  assign fall = ~echo_s & echo_prev_q;
  assign wrap = sub_q == SW'(CYCLES_PER_CM - 1);
  // cnt_q is reused as the trigger-width, rise-wait and echo-high timer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      per_q       <= '0;
      sub_q       <= '0;
      acc_q       <= '0;
      cm_q        <= '0;
      trig_q      <= 1'b0;
      valid_q     <= 1'b0;
      to_q        <= 1'b0;
      echo_prev_q <= 1'b0;
    end else begin
      valid_q     <= 1'b0;
      to_q        <= 1'b0;
      echo_prev_q <= echo_s;
      per_q       <= per_q + PW'(1);
      if (!enable) begin
        state_q <= IDLE;
        trig_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            state_q <= TRIG;
            trig_q  <= 1'b1;
            per_q   <= '0;
            cnt_q   <= '0;
          end
          TRIG: begin
            if (cnt_q == CW'(TRIG_CYCLES - 1)) begin
              state_q <= WAIT_RISE;
              trig_q  <= 1'b0;
              cnt_q   <= '0;
            end else cnt_q <= cnt_q + CW'(1);
          end
          WAIT_RISE: begin
            if (rise) begin
              state_q <= MEASURE;
              cnt_q   <= '0;
              sub_q   <= '0;
              acc_q   <= '0;
            end else if (cnt_q == CW'(ECHO_TIMEOUT - 1)) begin
              state_q <= HOLD;
              to_q    <= 1'b1;
            end else cnt_q <= cnt_q + CW'(1);
          end
          MEASURE: begin
            // a fall wins over a simultaneous timeout
            if (fall) begin
              state_q <= HOLD;
              cm_q    <= acc_q;
              valid_q <= 1'b1;
            end else if (cnt_q == CW'(ECHO_TIMEOUT - 1)) begin
              state_q <= HOLD;
              to_q    <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CW'(1);
              sub_q <= wrap ? '0 : sub_q + SW'(1);
              if (wrap && acc_q != 16'(MAX_CM)) acc_q <= acc_q + 16'd1;
            end
          end
          HOLD: begin
            if (per_q == PW'(PERIOD_CYCLES - 1)) begin
              state_q <= TRIG;
              trig_q  <= 1'b1;
              per_q   <= '0;
              cnt_q   <= '0;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end
  assign trigger = trig_q;
  assign cm      = cm_q;
  assign valid   = valid_q;
  assign timeout = to_q;
endmodule

// File: tb/tb_hcsr04_ranger.sv
// tb_hcsr04_ranger: randomized self-checking bench for hcsr04_ranger with shortened timing.
module tb_hcsr04_ranger;
  localparam int TC = 5, CPC = 10, TO = 200, PER = 600, MAXC = 15;
  logic        clk = 1'b0, reset = 1'b1, enable = 1'b0, echo = 1'b0;
  logic        trigger, valid, timeout;
  logic [15:0] cm;
  int n_chk = 0, n_fail = 0;
  int cyc = 0, nv = 0, nt = 0, nboth = 0;
  int last_start = 0;
  logic [15:0] cm_ref = 16'd0;

  hcsr04_ranger #(.CLK_HZ(50_000_000), .TRIG_CYCLES(TC), .CYCLES_PER_CM(CPC),
                  .ECHO_TIMEOUT(TO), .PERIOD_CYCLES(PER), .MAX_CM(MAXC)) dut (
    .clk(clk), .reset(reset), .enable(enable), .echo(echo),
    .trigger(trigger), .cm(cm), .valid(valid), .timeout(timeout));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (valid) nv <= nv + 1;
    if (timeout) nt <= nt + 1;
    if (valid && timeout) nboth <= nboth + 1;
  end

  function automatic logic [15:0] ref_cm(input int n);
    int c;
    c = n / CPC;
    return 16'(c > MAXC ? MAXC : c);
  endfunction

  // one full period: wait for trigger, measure its width, then echo high n cycles after d cycles
  task automatic run_meas(input int d, input int n, output int tlen, output int v, output int t);
    int k, v0, t0;
    v0 = nv; t0 = nt; k = 0;
    while (!trigger && k < 2000) begin @(negedge clk); k++; end
    last_start = cyc;
    tlen = 0;
    while (trigger && tlen < 100) begin @(negedge clk); tlen++; end
    repeat (d) @(negedge clk);
    if (n > 0) begin
      echo = 1'b1;
      repeat (n) @(negedge clk);
      echo = 1'b0;
    end
    repeat (n == 0 ? TO + 30 : 30) @(negedge clk);
    v = nv - v0; t = nt - t0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_chk++;
    if ({trigger, valid, timeout, cm} !== 19'd0) begin
      n_fail++;
      $display("FAIL reset: trig=%b valid=%b to=%b cm=%0d want all 0", trigger, valid, timeout, cm);
    end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++;
    if (trigger !== 1'b0) begin n_fail++; $display("FAIL idle_trigger: got %b want 0", trigger); end
  endtask

  task automatic check_meas(input string name, input int n, input int tlen, input int v, input int t);
    int ev, et;
    ev = (n > 0 && n <= TO) ? 1 : 0;
    et = 1 - ev;
    if (ev == 1) cm_ref = ref_cm(n);
    n_chk++;
    if (tlen != TC) begin n_fail++; $display("FAIL %s trig_len: got %0d want %0d", name, tlen, TC); end
    n_chk++;
    if (v != ev || t != et) begin
      n_fail++; $display("FAIL %s strobes: valid=%0d to=%0d want valid=%0d to=%0d", name, v, t, ev, et);
    end
    n_chk++;
    if (cm !== cm_ref) begin n_fail++; $display("FAIL %s cm: got %0d want %0d", name, cm, cm_ref); end
  endtask

  task automatic test_basic();
    int tl, v, t;
    @(negedge clk); enable = 1'b1;
    run_meas($urandom_range(0, 20), 73, tl, v, t);
    check_meas("basic73", 73, tl, v, t);
  endtask

  task automatic test_no_echo();
    int k, t0;
    k = 0;
    while (!trigger && k < 2000) begin @(negedge clk); k++; end
    while (trigger && k < 2100) begin @(negedge clk); k++; end
    t0 = nt; k = 0;
    while (!timeout && k < 400) begin @(negedge clk); k++; end
    n_chk++;
    if (k != TO) begin n_fail++; $display("FAIL no_echo latency: got %0d want %0d", k, TO); end
    repeat (5) @(negedge clk);
    n_chk++;
    if (nt - t0 != 1) begin n_fail++; $display("FAIL no_echo count: got %0d want 1", nt - t0); end
    n_chk++;
    if (cm !== cm_ref) begin n_fail++; $display("FAIL no_echo cm: got %0d want %0d", cm, cm_ref); end
  endtask

  task automatic test_long_echo();
    int tl, v, t, s;
    run_meas($urandom_range(0, 40), 500, tl, v, t);
    s = last_start;
    check_meas("long500", 500, tl, v, t);
    run_meas($urandom_range(0, 20), 190, tl, v, t);
    check_meas("sat190", 190, tl, v, t);
    n_chk++;
    if (last_start - s != PER) begin
      n_fail++; $display("FAIL period: got %0d want %0d", last_start - s, PER);
    end
  endtask

  task automatic test_random();
    int tl, v, t, n;
    for (int i = 0; i < 6; i++) begin
      do n = $urandom_range(1, 180); while (n % CPC == 0);
      run_meas($urandom_range(0, 40), n, tl, v, t);
      check_meas($sformatf("rand%0d_n%0d", i, n), n, tl, v, t);
    end
  endtask

  task automatic test_disable();
    int k, v0, t0, tl;
    k = 0;
    while (!trigger && k < 2000) begin @(negedge clk); k++; end
    while (trigger && k < 2100) begin @(negedge clk); k++; end
    repeat (3) @(negedge clk);
    echo = 1'b1;
    repeat (30) @(negedge clk);
    v0 = nv; t0 = nt;
    enable = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++;
    if (trigger !== 1'b0) begin n_fail++; $display("FAIL disable trigger: got %b want 0", trigger); end
    repeat (20) @(negedge clk);
    echo = 1'b0;
    repeat (TO + 50) @(negedge clk);
    n_chk++;
    if (nv != v0 || nt != t0 || cm !== cm_ref) begin
      n_fail++; $display("FAIL disable quiet: dv=%0d dt=%0d cm=%0d want 0 0 %0d", nv - v0, nt - t0, cm, cm_ref);
    end
    enable = 1'b1;
    @(negedge clk);
    n_chk++;
    if (trigger !== 1'b1) begin n_fail++; $display("FAIL reenable trigger: got %b want 1", trigger); end
    tl = 0;
    while (trigger && tl < 100) begin @(negedge clk); tl++; end
    n_chk++;
    if (tl != TC) begin n_fail++; $display("FAIL reenable trig_len: got %0d want %0d", tl, TC); end
  endtask

  task automatic test_async_reset();
    int k, tl, v, t;
    k = 0;
    while (!trigger && k < 2000) begin @(negedge clk); k++; end
    while (trigger && k < 2100) begin @(negedge clk); k++; end
    echo = 1'b1;
    repeat (20) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    n_chk++;
    if ({trigger, valid, timeout, cm} !== 19'd0) begin
      n_fail++;
      $display("FAIL async_reset: trig=%b valid=%b to=%b cm=%0d want all 0", trigger, valid, timeout, cm);
    end
    cm_ref = 16'd0;
    echo = 1'b0;
    @(negedge clk); reset = 1'b0;
    run_meas($urandom_range(0, 20), 35, tl, v, t);
    check_meas("after_reset35", 35, tl, v, t);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_no_echo();
    test_long_echo();
    test_random();
    test_disable();
    test_async_reset();
    n_chk++;
    if (nboth != 0) begin n_fail++; $display("FAIL both_strobes: got %0d want 0", nboth); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
